// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer and its neighbours.
// State encodings are fixed so the flop stage and debug taps can decode them.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CNT_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CNT_LO  = 2'd3
    } state_t;

    localparam int STABLE_DEFAULT = 4;
    localparam int CNT_W_DEFAULT  = 3;

    // The debounced level is high once a rising change has been accepted.
    function automatic logic levelOf(input state_t s);
        return (s == IDLE_HI) || (s == CNT_LO);
    endfunction

    function automatic logic isCounting(input state_t s);
        return (s == CNT_HI) || (s == CNT_LO);
    endfunction

endpackage

// File: rtl/btn_debounce_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both stages clear on reset.
// Also intended for the flop stage's set/reset inputs.
module sync2 (
    input  logic clk,
    input  logic r,
    input  logic a,
    output logic y
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (r) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= a;
            r_s2 <= r_s1;
        end
    end

    assign y = r_s2;

endmodule

// File: rtl/btn_debounce.sv
// Counter-based button debouncer: synchronized input, four-state FSM,
// registered level plus one-cycle rise/fall pulses and a busy flag.
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE = STABLE_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic r,
    input  logic btn,
    output logic d,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

    logic             w_s2;
    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_rise;
    logic             w_fall;
    logic             r_d;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    sync2 u_sync (
        .clk (clk),
        .r   (r),
        .a   (btn),
        .y   (w_s2)
    );

    // Outputs are derived from the next state so they line up with the state change.
    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= IDLE_LO;
            r_cnt   <= '0;
            r_d     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_d     <= levelOf(w_stateNext);
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            r_busy  <= isCounting(w_stateNext);
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        case (r_state)
            IDLE_LO: begin
                if (w_s2) begin
                    w_stateNext = CNT_HI;
                    w_cntNext   = CNT_W'(1);
                end
            end
            CNT_HI: begin
                if (!w_s2) begin
                    w_stateNext = IDLE_LO;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = IDLE_HI;
                    w_cntNext   = '0;
                    w_rise      = 1'b1;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!w_s2) begin
                    w_stateNext = CNT_LO;
                    w_cntNext   = CNT_W'(1);
                end
            end
            CNT_LO: begin
                if (w_s2) begin
                    w_stateNext = IDLE_HI;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = IDLE_LO;
                    w_cntNext   = '0;
                    w_fall      = 1'b1;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE_LO;
                w_cntNext   = '0;
            end
        endcase
    end

    assign d    = r_d;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed vector table, hand-written
// corner sequences, then random bouncing input against a run-length model.
module tb_btn_debounce;

    localparam int STABLE = 4;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic r;
    logic btn;
    logic d;
    logic rise;
    logic fall;
    logic busy;

    always #5 clk = ~clk;

    btn_debounce #(
        .STABLE (STABLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .r    (r),
        .btn  (btn),
        .d    (d),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    typedef struct {
        logic       rIn;
        logic       btnIn;
        logic [3:0] expOut;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    // Model: the FSM sees btn two edges late; d flips after STABLE disagreeing samples in a row.
    logic mQ[$];
    int   mRun;
    logic mD, mRise, mFall, mBusy;

    task automatic modelStep(input logic rIn, input logic bIn);
        logic sample;
        mRise = 1'b0;
        mFall = 1'b0;
        if (rIn) begin
            mQ.delete();
            mQ.push_back(1'b0);
            mQ.push_back(1'b0);
            mRun = 0;
            mD   = 1'b0;
        end else begin
            sample = mQ.pop_front();
            mQ.push_back(bIn);
            if (sample != mD) begin
                mRun++;
                if (mRun == STABLE) begin
                    mD = ~mD;
                    if (mD) mRise = 1'b1;
                    else    mFall = 1'b1;
                    mRun = 0;
                end
            end else begin
                mRun = 0;
            end
        end
        mBusy = (mRun > 0);
    endtask

    task automatic applyStimulus(input logic rIn, input logic bIn);
        r   = rIn;
        btn = bIn;
        @(posedge clk);
        #1;
        modelStep(rIn, bIn);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expv);
        compared++;
        if ({d, rise, fall, busy} !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: d/rise/fall/busy got %b expected %b at %0t",
                     name, {d, rise, fall, busy}, expv, $time);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic rIn, input logic bIn, input logic [3:0] e);
        vec_t v;
        v.rIn    = rIn;
        v.btnIn  = bIn;
        v.expOut = e;
        return v;
    endfunction

    vec_t vecs[23];

    initial begin
        int riseCount;
        int riseStep;
        int hold;
        logic bVal;
        logic rVal;

        r   = 1'b1;
        btn = 1'b0;

        // Expected outputs are {d, rise, fall, busy} after each edge.
        vecs[0]  = mk(1'b1, 1'b0, 4'b0000);
        vecs[1]  = mk(1'b1, 1'b1, 4'b0000);
        vecs[2]  = mk(1'b0, 1'b1, 4'b0000);
        vecs[3]  = mk(1'b0, 1'b1, 4'b0000);
        vecs[4]  = mk(1'b0, 1'b1, 4'b0001);
        vecs[5]  = mk(1'b0, 1'b1, 4'b0001);
        vecs[6]  = mk(1'b0, 1'b1, 4'b0001);
        vecs[7]  = mk(1'b0, 1'b1, 4'b1100);
        vecs[8]  = mk(1'b0, 1'b1, 4'b1000);
        vecs[9]  = mk(1'b0, 1'b0, 4'b1000);
        vecs[10] = mk(1'b0, 1'b0, 4'b1000);
        vecs[11] = mk(1'b0, 1'b0, 4'b1001);
        vecs[12] = mk(1'b0, 1'b0, 4'b1001);
        vecs[13] = mk(1'b0, 1'b0, 4'b1001);
        vecs[14] = mk(1'b0, 1'b0, 4'b0010);
        vecs[15] = mk(1'b0, 1'b0, 4'b0000);
        vecs[16] = mk(1'b0, 1'b1, 4'b0000);
        vecs[17] = mk(1'b0, 1'b1, 4'b0000);
        vecs[18] = mk(1'b0, 1'b1, 4'b0001);
        vecs[19] = mk(1'b0, 1'b0, 4'b0001);
        vecs[20] = mk(1'b0, 1'b0, 4'b0001);
        vecs[21] = mk(1'b0, 1'b0, 4'b0000);
        vecs[22] = mk(1'b0, 1'b0, 4'b0000);

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].rIn, vecs[i].btnIn);
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
        end

        // Bounce: high 2, low 1, then high; only the final run may produce rise.
        riseCount = 0;
        riseStep  = -1;
        for (int j = 0; j < 14; j++) begin
            applyStimulus(1'b0, (j == 2) ? 1'b0 : 1'b1);
            checkOutput($sformatf("bounce_step%0d", j), {mD, mRise, mFall, mBusy});
            if (rise) begin
                riseCount++;
                riseStep = j;
            end
        end
        checkValue("bounce_rise_count", riseCount, 1);
        checkValue("bounce_rise_step", riseStep, 8);
        checkValue("bounce_final_d", int'(d), 1);

        // Reset mid-count: clear, start a press, reset when the count has reached 2.
        applyStimulus(1'b1, 1'b0);
        checkOutput("midcount_pre_reset", 4'b0000);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("midcount_busy", 4'b0001);
        applyStimulus(1'b1, 1'b1);
        checkOutput("midcount_reset", 4'b0000);
        riseCount = 0;
        riseStep  = -1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1);
            if (rise) begin
                riseCount++;
                riseStep = k;
            end
        end
        checkValue("midcount_rise_count", riseCount, 1);
        checkValue("midcount_rise_step", riseStep, 5);
        checkValue("midcount_final_d", int'(d), 1);

        // Random bouncing with occasional resets, held values of varied length.
        hold = 0;
        bVal = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                bVal = $urandom_range(0, 1) != 0;
                hold = $urandom_range(1, 9);
            end
            hold--;
            rVal = ($urandom_range(0, 199) == 0);
            applyStimulus(rVal, bVal);
            checkOutput("random", {mD, mRise, mFall, mBusy});
            compared++;
            if (rise && fall) begin
                mismatched++;
                $display("[TB] FAIL random_pulse_exclusive: rise=%b fall=%b expected not both high", rise, fall);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Synchronizing, counter-based debouncer that turns a raw, asynchronous push-button or switch input into a clean single-bit level plus one-cycle edge pulses. It sits directly upstream of the lab's D flip-flop stage (`Dff_`). Its `d` output drives that stage's `d` input, and the `rise`/`fall` pulses can drive its `s`/`r` controls. It contains a two-flop synchronizer, a four-state debounce FSM and a stability counter, all on the same clock as the flop stage.

## Interface
Parameters:
- `STABLE`, default 4: number of consecutive synchronized samples that must disagree with the current `d` before `d` changes. Legal range 2 .. 2^`CNT_W`−1.
- `CNT_W`, default 3: stability-counter width.

Ports:
- `clk`  in  1  single clock for all state, rising-edge.
- `r`  in  1  reset, synchronous, active-high.
- `btn`  in  1  raw, asynchronous, possibly bouncing input.
- `d`  out  1  debounced level, registered.
- `rise`  out  1  one-cycle pulse in the cycle `d` becomes 1.
- `fall`  out  1  one-cycle pulse in the cycle `d` becomes 0.
- `busy`  out  1  high while a candidate change is being counted.

## Operation
- Synchronizer: `btn` → `s1` → `s2`, two flops, both reset to 0. Only `s2` feeds the FSM.
- States (2-bit): IDLE_LO, CNT_HI, IDLE_HI, CNT_LO. Reset state is IDLE_LO with `cnt`=0.
- IDLE_LO:
  - `s2`=1 → CNT_HI, `cnt`←1.
  - Otherwise hold.
- CNT_HI:
  - `s2`=0 → IDLE_LO, `cnt`←0, no pulse.
  - `s2`=1 and `cnt`=`STABLE`−1 → IDLE_HI, `cnt`←0, `rise`←1.
  - Otherwise `cnt`←`cnt`+1.
- IDLE_HI and CNT_LO mirror IDLE_LO and CNT_HI with polarity inverted; the terminal transition asserts `fall`.
- `d` is registered, 1 in IDLE_HI and CNT_LO, 0 otherwise.
- `busy` is registered, 1 in CNT_HI and CNT_LO.
- `rise`/`fall` are registered, cleared every cycle unless the terminal transition fires. They are never both high.
- Counter never exceeds `STABLE`−1 and never wraps.

## Timing
- Reset values: `d`=0, `rise`=0, `fall`=0, `busy`=0, `s1`=`s2`=0, `cnt`=0, state IDLE_LO.
- Reset takes effect at the first rising edge with `r`=1. `r` overrides every other input.
- Reset mid-count: the count is discarded. If `btn` is still high after release, a full fresh debounce runs and `rise` is emitted.
- Latency: `btn` changes and meets setup before edge E0 and then stays stable. Then `s2` changes after E1, counting runs over edges E2..E(`STABLE`+1), and `d`, `rise`/`fall` update after edge E(`STABLE`+1).
- Default `STABLE`=4 with a 10 ns clock: 50 ns from edge E0 to `d` change.
- Any `s2` sample equal to the current `d` during counting aborts the count, returns to the idle state, and clears `busy` on the next edge.
- A run of `STABLE`−1 samples followed by one disagreeing sample produces no pulse. A bounce restarts counting from 1.
- A change of `btn` that is not captured by `s1` is not seen, by construction.

## Structure
- Shared package `debounce_pkg`: state encodings IDLE_LO=2'd0, CNT_HI=2'd1, IDLE_HI=2'd2, CNT_LO=2'd3.
- One sub-module `sync2` (two-flop synchronizer, ports `clk`, `r`, `a`, `y`), reused later for the flop stage's `s`/`r` inputs.
- FSM, counter and output registers live in `btn_debounce` itself.

## Test plan
All scenarios use `STABLE`=4 and a 10 ns clock.
- Reset: `r`=1 for 2 cycles with `btn`=1 → `d`=`rise`=`fall`=`busy`=0 throughout. After release, `rise` pulses once, 50 ns after the first edge with `r`=0.
- Clean press: `btn` 0→1 before edge E0 → `busy`=1 after E2. After E5, `d`=1 and `rise`=1 for exactly one cycle. After E6, `busy`=0 and `rise`=0.
- Bounce: `btn` high for 2 cycles, low for 1, then high → no `rise` during the bounce. `d`=1 only 4 samples after the final rise is synchronized. Exactly one `rise` pulse.
- Release: from `d`=1, `btn`→0 and held → `fall` pulses once, `d`=0 after the latency above, `rise` stays 0.
- Near miss: `btn` high for exactly 3 sampled cycles, then low → `d` stays 0, no pulse, `busy` 1 then 0.
- Reset mid-count: `r`=1 at the cycle where `cnt`=2 → state cleared. With `btn` still high, `d` rises 4 samples after the post-reset synchronizer refills.
